// File: rtl/bcd_display_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : bcd_display_scan                                              |
// | Brief  : 3-digit multiplexed 7-segment driver with frame-synchronous   |
// |          double buffering of the hundreds/tens/units BCD digits.       |
// | Ports  : CLK   - system clock, all state on rising edge                 |
// |          RST   - synchronous active-high reset                         |
// |          H/T/O - hundreds/tens/units BCD digits, captured on LOAD      |
// |          LOAD  - one-cycle capture strobe                              |
// |          BUSY  - captured value waiting for the next frame boundary    |
// |          FRAME - one-cycle pulse on the boundary TICK                  |
// |          SEG   - {g,f,e,d,c,b,a}, active-low, registered               |
// |          AN    - {hundreds,tens,units} anode enables, active-low, reg. |
// | Config : LZ_BLANK_EN - leading-zero blanking of hundreds/tens          |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module bcd_display_scan #(
    parameter int PRESCALE = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] H,
    input  logic [3:0] T,
    input  logic [3:0] O,
    input  logic       LOAD,
    output logic       BUSY,
    output logic       FRAME,
    output logic [6:0] SEG,
    output logic [2:0] AN
);

    localparam int            CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_CNT_MAX = CW'(PRESCALE - 1);

    // Scan states. S_DARK is the post-reset slot before the first TICK:
    // nothing is lit yet, and its TICK lights units without ending a frame.
    localparam logic [1:0] S_UNITS    = 2'd0;
    localparam logic [1:0] S_TENS     = 2'd1;
    localparam logic [1:0] S_HUNDREDS = 2'd2;
    localparam logic [1:0] S_DARK     = 2'd3;

    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          w_tick;
    logic          w_boundary;

    logic [3:0]    r_ph, r_pt, r_po;
    logic [3:0]    r_dh, r_dt, r_do;
    logic [3:0]    w_dh_next, w_dt_next, w_do_next;
    logic          r_pend;

    logic          w_blank_h, w_blank_t;
    logic [6:0]    w_seg_next;
    logic [2:0]    w_an_next;
    logic [6:0]    r_seg;
    logic [2:0]    r_an;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h40;
            4'd1:    f_decode = 7'h79;
            4'd2:    f_decode = 7'h24;
            4'd3:    f_decode = 7'h30;
            4'd4:    f_decode = 7'h19;
            4'd5:    f_decode = 7'h12;
            4'd6:    f_decode = 7'h02;
            4'd7:    f_decode = 7'h78;
            4'd8:    f_decode = 7'h00;
            4'd9:    f_decode = 7'h10;
            default: f_decode = 7'h3F;  // non-BCD code shows a dash
        endcase
    endfunction

    // ---------------- prescaler ----------------
    assign w_tick = (r_cnt == c_CNT_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // ---------------- scan FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_DARK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- scan FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                S_UNITS:    w_state_next = S_TENS;
                S_TENS:     w_state_next = S_HUNDREDS;
                default:    w_state_next = S_UNITS;  // hundreds or dark
            endcase
        end
    end

    assign w_boundary = w_tick && (r_state == S_HUNDREDS);

    // ---------------- double buffer ----------------
    // A LOAD on the boundary TICK bypasses the pending buffer entirely so
    // the newest value wins and a stale pending value is never shown.
    always_comb begin
        w_dh_next = r_dh;
        w_dt_next = r_dt;
        w_do_next = r_do;
        if (w_boundary) begin
            if (LOAD) begin
                w_dh_next = H;
                w_dt_next = T;
                w_do_next = O;
            end else if (r_pend) begin
                w_dh_next = r_ph;
                w_dt_next = r_pt;
                w_do_next = r_po;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ph   <= '0;
            r_pt   <= '0;
            r_po   <= '0;
            r_dh   <= '0;
            r_dt   <= '0;
            r_do   <= '0;
            r_pend <= 1'b0;
        end else begin
            r_dh <= w_dh_next;
            r_dt <= w_dt_next;
            r_do <= w_do_next;
            if (LOAD && !w_boundary) begin
                r_ph   <= H;
                r_pt   <= T;
                r_po   <= O;
                r_pend <= 1'b1;
            end else if (w_boundary) begin
                r_pend <= 1'b0;
            end
        end
    end

    // ---------------- scan FSM: outputs ----------------
`ifdef LZ_BLANK_EN
    // Only a numeric zero is a leading zero; invalid codes stay visible.
    assign w_blank_h = (w_dh_next == 4'd0);
    assign w_blank_t = w_blank_h && (w_dt_next == 4'd0);
`else
    assign w_blank_h = 1'b0;
    assign w_blank_t = 1'b0;
`endif

    // Computed from the next state and next display values so a frame swap
    // is visible on the very edge that returns the scan to units.
    always_comb begin
        w_seg_next = c_SEG_BLANK;
        w_an_next  = 3'b111;
        case (w_state_next)
            S_UNITS: begin
                w_an_next  = 3'b110;
                w_seg_next = f_decode(w_do_next);
            end
            S_TENS: begin
                w_an_next  = 3'b101;
                w_seg_next = w_blank_t ? c_SEG_BLANK : f_decode(w_dt_next);
            end
            S_HUNDREDS: begin
                w_an_next  = 3'b011;
                w_seg_next = w_blank_h ? c_SEG_BLANK : f_decode(w_dh_next);
            end
            default: begin
                w_an_next  = 3'b111;
                w_seg_next = c_SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_seg <= c_SEG_BLANK;
            r_an  <= 3'b111;
        end else if (w_tick) begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign SEG   = r_seg;
    assign AN    = r_an;
    assign BUSY  = r_pend;
    assign FRAME = w_boundary;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_bcd_display_scan                                           |
// | Brief  : Self-checking bench for bcd_display_scan (PRESCALE = 4):      |
// |          reset, scan order, no-tearing swap, LOAD/boundary collision,  |
// |          invalid codes, leading zeros, reset mid-frame.                |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_bcd_display_scan;

    localparam int PRESCALE = 4;

    logic       CLK;
    logic       RST;
    logic [3:0] H, T, O;
    logic       LOAD;
    logic       BUSY, FRAME;
    logic [6:0] SEG;
    logic [2:0] AN;

    int total = 0;
    int bad   = 0;

    bcd_display_scan #(.PRESCALE(PRESCALE)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .H     (H),
        .T     (T),
        .O     (O),
        .LOAD  (LOAD),
        .BUSY  (BUSY),
        .FRAME (FRAME),
        .SEG   (SEG),
        .AN    (AN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] h, t, o;
        logic [6:0] su, st, sh;  // expected units/tens/hundreds segments
    } vec_t;

    vec_t vecs[6];

`ifdef LZ_BLANK_EN
    localparam logic [6:0] c_Z_LEAD = 7'h7F;
`else
    localparam logic [6:0] c_Z_LEAD = 7'h40;
`endif

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        H    = h;
        T    = t;
        O    = o;
        LOAD = 1'b1;
        step(1);
        LOAD = 1'b0;
    endtask

    logic [6:0] prev_su, prev_st, prev_sh;

    initial begin
        vecs[0] = '{h: 4'd1, t: 4'd2, o: 4'd3, su: 7'h30, st: 7'h24, sh: 7'h79};
        vecs[1] = '{h: 4'd4, t: 4'd5, o: 4'd6, su: 7'h02, st: 7'h12, sh: 7'h19};
        vecs[2] = '{h: 4'd0, t: 4'd0, o: 4'hC, su: 7'h3F, st: c_Z_LEAD, sh: c_Z_LEAD};
        vecs[3] = '{h: 4'd9, t: 4'd8, o: 4'd7, su: 7'h78, st: 7'h00, sh: 7'h10};
        vecs[4] = '{h: 4'd0, t: 4'd7, o: 4'd0, su: 7'h40, st: 7'h78, sh: c_Z_LEAD};
        vecs[5] = '{h: 4'hF, t: 4'd0, o: 4'd0, su: 7'h40, st: 7'h40, sh: 7'h3F};

        RST  = 1'b1;
        LOAD = 1'b0;
        H    = '0;
        T    = '0;
        O    = '0;

        // ---- reset held 3 cycles ----
        step(3);
        check("reset_seg",   {1'b0, SEG}, 8'h7F);
        check("reset_an",    {5'b0, AN},  8'h07);
        check("reset_busy",  {7'b0, BUSY}, 8'h00);
        check("reset_frame", {7'b0, FRAME}, 8'h00);

        // ---- first TICK: units lit on the 4th edge after release ----
        RST = 1'b0;
        step(3);
        check("dark_an", {5'b0, AN}, 8'h07);
        step(1);
        check("first_an",  {5'b0, AN},  8'h06);
        check("first_seg", {1'b0, SEG}, 8'h40);

        prev_su = 7'h40;
        prev_st = c_Z_LEAD;
        prev_sh = c_Z_LEAD;

        // ---- table: load mid-frame during units, verify old slots, then swap ----
        for (int v = 0; v < 6; v++) begin
            load_digits(vecs[v].h, vecs[v].t, vecs[v].o);
            check("ld_busy",  {7'b0, BUSY}, 8'h01);
            check("ld_frame", {7'b0, FRAME}, 8'h00);
            step(3);
            check("old_tens_an",  {5'b0, AN},  8'h05);
            check("old_tens_seg", {1'b0, SEG}, {1'b0, prev_st});
            step(4);
            check("old_hund_an",  {5'b0, AN},  8'h03);
            check("old_hund_seg", {1'b0, SEG}, {1'b0, prev_sh});
            step(3);
            check("bnd_frame", {7'b0, FRAME}, 8'h01);
            check("bnd_busy",  {7'b0, BUSY},  8'h01);
            step(1);
            check("new_busy",      {7'b0, BUSY},  8'h00);
            check("new_frame",     {7'b0, FRAME}, 8'h00);
            check("new_units_an",  {5'b0, AN},    8'h06);
            check("new_units_seg", {1'b0, SEG},   {1'b0, vecs[v].su});
            step(4);
            check("new_tens_an",  {5'b0, AN},  8'h05);
            check("new_tens_seg", {1'b0, SEG}, {1'b0, vecs[v].st});
            step(4);
            check("new_hund_an",  {5'b0, AN},  8'h03);
            check("new_hund_seg", {1'b0, SEG}, {1'b0, vecs[v].sh});
            step(4);
            check("wrap_units_seg", {1'b0, SEG}, {1'b0, vecs[v].su});
            prev_su = vecs[v].su;
            prev_st = vecs[v].st;
            prev_sh = vecs[v].sh;
        end

        // ---- collision: LOAD 9/9/9 on the boundary TICK with 7/7/7 pending ----
        load_digits(4'd7, 4'd7, 4'd7);
        check("col_busy", {7'b0, BUSY}, 8'h01);
        step(10);
        check("col_frame", {7'b0, FRAME}, 8'h01);
        H    = 4'd9;
        T    = 4'd9;
        O    = 4'd9;
        LOAD = 1'b1;
        step(1);
        LOAD = 1'b0;
        check("col_busy_after", {7'b0, BUSY}, 8'h00);
        check("col_units",      {1'b0, SEG},  8'h10);
        step(4);
        check("col_tens", {1'b0, SEG}, 8'h10);
        step(4);
        check("col_hund", {1'b0, SEG}, 8'h10);
        step(3);
        check("col_frame2", {7'b0, FRAME}, 8'h01);
        check("col_busy2",  {7'b0, BUSY},  8'h00);
        step(1);
        check("col_units2", {1'b0, SEG}, 8'h10);

        // ---- reset mid-frame with a pending value, during the tens slot ----
        load_digits(4'd1, 4'd2, 4'd3);
        step(3);
        check("mid_tens_an", {5'b0, AN}, 8'h05);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        check("mid_rst_seg",  {1'b0, SEG},  8'h7F);
        check("mid_rst_an",   {5'b0, AN},   8'h07);
        check("mid_rst_busy", {7'b0, BUSY}, 8'h00);
        step(3);
        check("mid_dark_an", {5'b0, AN}, 8'h07);
        step(1);
        check("mid_first_an",  {5'b0, AN},  8'h06);
        check("mid_first_seg", {1'b0, SEG}, 8'h40);
        step(8);
        check("mid_hund_seg",  {1'b0, SEG},  {1'b0, c_Z_LEAD});
        check("mid_hund_busy", {7'b0, BUSY}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
